// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline MEM stage and the data-memory responder.
interface dmem_responder_if;
    logic        memReq;
    logic        memWrite;
    logic [31:0] memAddr;
    logic [31:0] memWriteData;
    logic        memReady;
    logic [31:0] memReadData;
    logic        memError;
    logic        memStall;

    modport master (
        output memReq, memWrite, memAddr, memWriteData,
        input  memReady, memReadData, memError, memStall
    );

    modport slave (
        input  memReq, memWrite, memAddr, memWriteData,
        output memReady, memReadData, memError, memStall
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one word access at a time, waits
// LATENCY cycles, then commits the store or returns load data for one cycle.
module dmem_responder #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned LATENCY   = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_BITS = ADDR_BITS - 2;
    localparam int unsigned DEPTH    = 1 << IDX_BITS;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          r_state;
    logic [3:0]          r_cnt;
    logic                r_write;
    logic [IDX_BITS-1:0] r_idx;
    logic [1:0]          r_off;
    logic [31:0]         r_wdata;
    logic [31:0]         r_mem [DEPTH];

    logic        w_ready;
    logic        w_misalign;
    logic        w_wr_en;
    logic [31:0] w_rdata;
    logic        w_unused_addr;

    // Upper address bits alias onto the array and are deliberately dropped.
    assign w_unused_addr = ^bus.memAddr[31:ADDR_BITS];

    // Handshake FSM: latch request on acceptance, count wait states, complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_off   <= 2'b00;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.memReq) begin
                        r_write <= bus.memWrite;
                        r_idx   <= bus.memAddr[ADDR_BITS-1:2];
                        r_off   <= bus.memAddr[1:0];
                        r_wdata <= bus.memWriteData;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Completion decode; reset masks the ready cycle so a pending store is dropped.
    always_comb begin
        w_ready    = (r_state == ST_BUSY) && (r_cnt == 4'd0) && !reset;
        w_misalign = (r_off != 2'b00);
        w_wr_en    = w_ready && r_write && !w_misalign;
        w_rdata    = '0;
        if (w_ready && !r_write && !w_misalign) begin
            w_rdata = r_mem[r_idx];
        end
    end

    // Storage array: not reset, written only at the edge ending an aligned store's ready cycle.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.memReady    = w_ready;
    assign bus.memError    = w_ready && w_misalign;
    assign bus.memReadData = w_rdata;
    assign bus.memStall    = bus.memReq && !w_ready;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: stimulus pushes expected responses into a
// scoreboard, a negedge monitor pops and compares on every memReady pulse.
module tb_dmem_responder;

    localparam int unsigned LAT = 2;

    logic clk = 1'b0;
    logic reset;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_BITS(14), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
        bit          chk;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_ready = -100;
    int prev_ready = -100;
    bit prev_rdy   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: compares every completion against the scoreboard head.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("ready_in_reset", {31'd0, bus.memReady}, 32'd0);
            prev_rdy = 1'b0;
        end else begin
            if (bus.memReady === 1'b1) begin
                check("no_consecutive_ready", {31'd0, prev_rdy}, 32'd0);
                prev_ready = last_ready;
                last_ready = cyc;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready: got memReady=1 with no outstanding request, expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    check({mon_e.name, "_err"}, {31'd0, bus.memError}, {31'd0, mon_e.err});
                    if (mon_e.chk) check({mon_e.name, "_data"}, bus.memReadData, mon_e.data);
                end
            end else begin
                check("rdata_zero_when_not_ready", bus.memReadData, 32'd0);
            end
            prev_rdy = (bus.memReady === 1'b1);
        end
    end

    // Issue one access starting in the current cycle; checks stall and latency.
    task automatic access(input string nm, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input bit eerr, input logic [31:0] edata, input bit chk, input bit hold);
        int n;
        bit got;
        exp_t e;
        e.err  = eerr;
        e.data = edata;
        e.chk  = chk;
        e.name = nm;
        sb.push_back(e);
        bus.memReq       = 1'b1;
        bus.memWrite     = w;
        bus.memAddr      = a;
        bus.memWriteData = d;
        n   = 0;
        got = 1'b0;
        while (!got && n <= 20) begin
            @(negedge clk);
            if (bus.memReady === 1'b1) begin
                got = 1'b1;
            end else begin
                check({nm, "_stall"}, {31'd0, bus.memStall}, 32'd1);
                n++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no memReady within 20 cycles, expected one after %0d", nm, LAT);
        end else begin
            check({nm, "_latency"}, 32'(n), 32'(LAT));
            check({nm, "_stall_at_ready"}, {31'd0, bus.memStall}, 32'd0);
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus.memReq       = 1'b0;
            bus.memWrite     = 1'b0;
            bus.memAddr      = '0;
            bus.memWriteData = '0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset            = 1'b1;
        bus.memReq       = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddr      = '0;
        bus.memWriteData = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Quiet outputs after reset release.
        repeat (5) begin
            @(negedge clk);
            check("post_reset_ready", {31'd0, bus.memReady}, 32'd0);
            check("post_reset_rdata", bus.memReadData, 32'd0);
            check("post_reset_err",   {31'd0, bus.memError}, 32'd0);
            check("post_reset_stall", {31'd0, bus.memStall}, 32'd0);
        end
        idle_cycle();

        access("st10", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        idle_cycle();
        access("ld10", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        idle_cycle();

        // Continuous memReq: accesses complete LATENCY+1 cycles apart.
        access("st20", 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b1);
        access("ld20", 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
        check("b2b_gap_1", 32'(last_ready - prev_ready), 32'(LAT + 1));
        access("ld4020_alias", 1'b0, 32'h0000_4020, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
        check("b2b_gap_2", 32'(last_ready - prev_ready), 32'(LAT + 1));
        idle_cycle();

        access("st13_misaligned", 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b0);
        access("ld10_after_mis", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        access("ld22_misaligned", 1'b0, 32'h0000_0022, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
        idle_cycle();

        // Store accepted, then reset the next cycle: no completion, no write.
        bus.memReq       = 1'b1;
        bus.memWrite     = 1'b1;
        bus.memAddr      = 32'h0000_0010;
        bus.memWriteData = 32'hCAFE_F00D;
        idle_cycle();
        reset            = 1'b1;
        bus.memReq       = 1'b0;
        bus.memWrite     = 1'b0;
        bus.memAddr      = '0;
        bus.memWriteData = '0;
        idle_cycle();
        idle_cycle();
        reset = 1'b0;
        repeat (3) idle_cycle();
        access("ld10_after_reset", 1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0);

        repeat (3) idle_cycle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
